// File: rtl/goldschmidt_round_if.sv
// ---------------------------------------------------------------------------
// goldschmidt_round_if
//   Operand and result channels of the Goldschmidt finalisation stage.
//
//   Handshake rule, applies to both channels: a transfer happens on a rising
//   clk edge where valid and ready are both 1. A source holds valid and its
//   payload stable until that transfer. A sink may drive ready regardless of
//   valid.
//
//   Operand channel (upstream controller -> rounding stage)
//     in_valid, in_ready, op, q, r_sign, sign, rm
//   Result channel (rounding stage -> FP packing logic)
//     out_valid, out_ready, mant, exp_adj, inexact
//
//   Modports
//     master : upstream/downstream environment (drives operands, out_ready)
//     slave  : the rounding stage itself
// ---------------------------------------------------------------------------
interface goldschmidt_round_if #(
  parameter int LEADS = 2,
  parameter int WIDTH = 28,
  parameter int OUTW  = 24
);

  // operand channel
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             op;
  logic [LEADS+WIDTH-1:0] q;
  logic                   r_sign;
  logic                   sign;
  logic [2:0]             rm;

  // result channel
  logic                   out_valid;
  logic                   out_ready;
  logic [OUTW-1:0]        mant;
  logic [2:0]             exp_adj;
  logic                   inexact;

  modport master (
    output in_valid, op, q, r_sign, sign, rm, out_ready,
    input  in_ready, out_valid, mant, exp_adj, inexact
  );

  modport slave (
    input  in_valid, op, q, r_sign, sign, rm, out_ready,
    output in_ready, out_valid, mant, exp_adj, inexact
  );

endinterface

// File: rtl/goldschmidt_round.sv
// ---------------------------------------------------------------------------
// goldschmidt_round
//   Finalisation stage of the Goldschmidt divide/sqrt datapath. Captures the
//   raw iteration result, applies the one-ulp remainder correction for
//   division, normalises to a leading one, rounds to an OUTW-bit mantissa
//   and hands the result to the FP packing logic.
//
//   Pipeline of states: IDLE -> CORR -> NORM -> RND -> HOLD -> IDLE
//   An operand accepted in cycle 0 is presented (out_valid=1) in cycle 4.
//
//   Ports
//     clk       : clock
//     reset     : asynchronous, active-high reset
//     flush     : synchronous abort, returns the FSM to IDLE
//     bus       : operand/result channels (slave side)
//     state_dbg : current FSM state, for observation only
//
//   Parameters
//     LEADS : integer bits of q
//     WIDTH : fraction bits of q
//     OUTW  : output mantissa width including hidden bit (OUTW <= WIDTH-2)
// ---------------------------------------------------------------------------
module goldschmidt_round #(
  parameter int LEADS = 2,
  parameter int WIDTH = 28,
  parameter int OUTW  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  goldschmidt_round_if.slave   bus,
  output logic [2:0]           state_dbg
);

  localparam int S = LEADS + WIDTH;  // total width of q
  localparam int L = WIDTH;          // index of the ones bit of q

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CORR = 3'd1;
  localparam logic [2:0] NORM = 3'd2;
  localparam logic [2:0] RND  = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RZ  = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [S-1:0]    Q_ONE     = {{(S-1){1'b0}}, 1'b1};
  localparam logic [OUTW-1:0] MANT_ONES = {OUTW{1'b1}};
  localparam logic [OUTW-1:0] MANT_MSB  = {1'b1, {(OUTW-1){1'b0}}};

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  logic [2:0] state;
  logic [2:0] state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = CORR;
      CORR:                       state_nx = NORM;
      NORM:                       state_nx = RND;
      RND:                        state_nx = HOLD;
      HOLD:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
    // abort wins over every transition, including an accept in IDLE
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == HOLD);
  assign state_dbg     = state;

  // -------------------------------------------------------------------------
  // Operand capture (IDLE)
  // -------------------------------------------------------------------------
  logic [S-1:0] q_r;
  logic         r_sign_r;
  logic [1:0]   op_r;
  logic         sign_r;
  logic [2:0]   rm_r;

  logic accept;
  assign accept = (state == IDLE) && bus.in_valid && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r      <= '0;
      r_sign_r <= 1'b0;
      op_r     <= 2'b00;
      sign_r   <= 1'b0;
      rm_r     <= 3'b000;
    end else if (accept) begin
      q_r      <= bus.q;
      r_sign_r <= bus.r_sign;
      op_r     <= bus.op;
      sign_r   <= bus.sign;
      rm_r     <= bus.rm;
    end
  end

  // -------------------------------------------------------------------------
  // Remainder correction (CORR)
  //   A positive remainder sign means q*d overshot n, so the quotient is one
  //   ulp too large. Sqrt results and a zero quotient are left untouched.
  // -------------------------------------------------------------------------
  logic [S-1:0] qc_r;
  logic         dec_r;
  logic         do_dec;

  assign do_dec = (op_r == 2'b00) && r_sign_r && (q_r != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qc_r  <= '0;
      dec_r <= 1'b0;
    end else if (state == CORR) begin
      qc_r  <= do_dec ? (q_r - Q_ONE) : q_r;
      dec_r <= do_dec;
    end
  end

  // -------------------------------------------------------------------------
  // Normalisation (NORM)
  //   The leading one can only sit in one of three positions around the ones
  //   bit, so each candidate window is a fixed slice and a priority select
  //   picks one. OUTW <= WIDTH-2 keeps every sticky slice non-empty.
  // -------------------------------------------------------------------------
  logic [OUTW-1:0] win_hi, win_mid, win_lo;
  logic            g_hi, g_mid, g_lo;
  logic            s_hi, s_mid, s_lo;

  assign win_hi  = qc_r[L+1 -: OUTW];
  assign g_hi    = qc_r[L+1-OUTW];
  assign s_hi    = |qc_r[L-OUTW:0];

  assign win_mid = qc_r[L -: OUTW];
  assign g_mid   = qc_r[L-OUTW];
  assign s_mid   = |qc_r[L-OUTW-1:0];

  assign win_lo  = qc_r[L-1 -: OUTW];
  assign g_lo    = qc_r[L-1-OUTW];
  assign s_lo    = |qc_r[L-OUTW-2:0];

  logic [OUTW-1:0] win_nx;
  logic            g_nx;
  logic            s_nx;
  logic [2:0]      e_nx;

  always_comb begin
    win_nx = '0;
    g_nx   = 1'b0;
    s_nx   = 1'b0;
    e_nx   = 3'b000;
    if (qc_r[L+1]) begin
      win_nx = win_hi;
      g_nx   = g_hi;
      s_nx   = s_hi;
      e_nx   = 3'b001;
    end else if (qc_r[L]) begin
      win_nx = win_mid;
      g_nx   = g_mid;
      s_nx   = s_mid;
      e_nx   = 3'b000;
    end else if (qc_r[L-1]) begin
      win_nx = win_lo;
      g_nx   = g_lo;
      s_nx   = s_lo;
      e_nx   = 3'b111;  // -1
    end
    // no leading one in range: zero result, all fields stay 0
  end

  logic [OUTW-1:0] win_r;
  logic            g_r;
  logic            s_r;
  logic [2:0]      e_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_r <= '0;
      g_r   <= 1'b0;
      s_r   <= 1'b0;
      e_r   <= 3'b000;
    end else if (state == NORM) begin
      win_r <= win_nx;
      g_r   <= g_nx;
      s_r   <= s_nx;
      e_r   <= e_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Rounding (RND)
  // -------------------------------------------------------------------------
  logic roundup;

  always_comb begin
    roundup = 1'b0;
    case (rm_r)
      RM_RNE:  roundup = g_r & (s_r | win_r[0]);
      RM_RZ:   roundup = 1'b0;
      RM_RDN:  roundup = sign_r & (g_r | s_r);
      RM_RUP:  roundup = ~sign_r & (g_r | s_r);
      RM_RMM:  roundup = g_r;
      default: roundup = g_r & (s_r | win_r[0]);  // unused encodings round as RNE
    endcase
  end

  logic [OUTW-1:0] mant_nx;
  logic [2:0]      exp_nx;

  always_comb begin
    mant_nx = win_r + {{(OUTW-1){1'b0}}, roundup};
    exp_nx  = e_r;
    // rounding carried out of the window: renormalise to 1.000...
    if (roundup && (win_r == MANT_ONES)) begin
      mant_nx = MANT_MSB;
      exp_nx  = e_r + 3'd1;
    end
  end

  // Result registers keep their last values across a flush; only reset
  // clears them.
  logic [OUTW-1:0] mant_r;
  logic [2:0]      exp_adj_r;
  logic            inexact_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mant_r    <= '0;
      exp_adj_r <= 3'b000;
      inexact_r <= 1'b0;
    end else if ((state == RND) && !flush) begin
      mant_r    <= mant_nx;
      exp_adj_r <= exp_nx;
      inexact_r <= g_r | s_r | dec_r;
    end
  end

  assign bus.mant    = mant_r;
  assign bus.exp_adj = exp_adj_r;
  assign bus.inexact = inexact_r;

endmodule

// File: tb/tb_goldschmidt_round.sv
// ---------------------------------------------------------------------------
// tb_goldschmidt_round
//   Directed-vector bench for goldschmidt_round. Expected results are
//   hand-computed for LEADS=2, WIDTH=28, OUTW=24 and queued before each
//   operand is sent.
// ---------------------------------------------------------------------------
module tb_goldschmidt_round;

  localparam int LEADS = 2;
  localparam int WIDTH = 28;
  localparam int OUTW  = 24;
  localparam int W     = 3 + 1 + OUTW;  // {exp_adj, inexact, mant}

  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RZ  = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_NORM = 3'd2;
  localparam logic [2:0] ST_RND  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  // -------------------------------------------------------------------------
  // clock / reset
  // -------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  goldschmidt_round_if #(.LEADS(LEADS), .WIDTH(WIDTH), .OUTW(OUTW)) bus ();

  goldschmidt_round #(.LEADS(LEADS), .WIDTH(WIDTH), .OUTW(OUTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // scoreboard
  // -------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // driver tasks
  // -------------------------------------------------------------------------
  // Presents one operand at a falling edge and returns just after the
  // rising edge on which it was accepted.
  task automatic drive_op(input logic [29:0] qv, input logic rs,
                          input logic [1:0] opv, input logic sg,
                          input logic [2:0] rmv);
    int waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_send", bus.in_ready, 1);
    bus.q        = qv;
    bus.r_sign   = rs;
    bus.op       = opv;
    bus.sign     = sg;
    bus.rm       = rmv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until out_valid is seen; cycle 1 is
  // the one immediately after the accept.
  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 20) begin
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
    end
  endtask

  task automatic take_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_out_valid_drop"}, bus.out_valid, 0);
    check({tag, "_in_ready_back"}, bus.in_ready, 1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic run_vec(input string tag, input logic [29:0] qv,
                         input logic rs, input logic [1:0] opv,
                         input logic sg, input logic [2:0] rmv,
                         input logic [23:0] em, input logic [2:0] ea,
                         input logic ei);
    int           lat;
    logic [W-1:0] e;
    exp_q.push_back({ea, ei, em});
    drive_op(qv, rs, opv, sg, rmv);
    wait_result(lat);
    check({tag, "_latency"}, lat, 4);
    e = exp_q.pop_front();
    check({tag, "_mant"},    bus.mant,    e[OUTW-1:0]);
    check({tag, "_exp_adj"}, bus.exp_adj, e[W-1 -: 3]);
    check({tag, "_inexact"}, bus.inexact, e[OUTW]);
    check({tag, "_in_ready_busy"}, bus.in_ready, 0);
    take_result(tag);
  endtask

  // -------------------------------------------------------------------------
  // stimulus
  // -------------------------------------------------------------------------
  initial begin
    int lat;

    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.q         = '0;
    bus.r_sign    = 1'b0;
    bus.op        = 2'b00;
    bus.sign      = 1'b0;
    bus.rm        = RNE;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mant",      bus.mant,      0);
    check("rst_exp_adj",   bus.exp_adj,   0);
    check("rst_inexact",   bus.inexact,   0);
    check("rst_state",     state_dbg,     ST_IDLE);
    reset = 1'b0;

    // ---- main function
    run_vec("exact",       30'h1000_0000, 0, 2'b00, 0, RNE,    24'h800000, 3'b000, 0);
    run_vec("tie_even",    30'h1000_0010, 0, 2'b00, 0, RNE,    24'h800000, 3'b000, 1);
    run_vec("rup_pos",     30'h1000_0010, 0, 2'b00, 0, RUP,    24'h800001, 3'b000, 1);
    run_vec("rup_neg",     30'h1000_0010, 0, 2'b00, 1, RUP,    24'h800000, 3'b000, 1);
    run_vec("dec_carry",   30'h1000_0000, 1, 2'b00, 0, RNE,    24'h800000, 3'b000, 1);
    run_vec("sqrt_nodec",  30'h1000_0000, 1, 2'b01, 0, RNE,    24'h800000, 3'b000, 0);
    run_vec("hi_bit",      30'h2000_0000, 0, 2'b00, 0, RNE,    24'h800000, 3'b001, 0);
    run_vec("zero",        30'h0000_0000, 1, 2'b00, 0, RNE,    24'h000000, 3'b000, 0);
    run_vec("tie_odd",     30'h1000_0030, 0, 2'b00, 0, RNE,    24'h800002, 3'b000, 1);
    run_vec("rz",          30'h1000_0018, 0, 2'b00, 0, RZ,     24'h800000, 3'b000, 1);
    run_vec("rmm_tie",     30'h1000_0010, 0, 2'b00, 0, RMM,    24'h800001, 3'b000, 1);
    run_vec("rdn_neg",     30'h1000_0018, 0, 2'b00, 1, RDN,    24'h800001, 3'b000, 1);
    run_vec("rdn_pos",     30'h1000_0018, 0, 2'b00, 0, RDN,    24'h800000, 3'b000, 1);
    run_vec("lo_bit",      30'h0800_0000, 0, 2'b00, 0, RNE,    24'h800000, 3'b111, 0);
    run_vec("ones_rz",     30'h0FFF_FFFF, 0, 2'b01, 0, RZ,     24'hFFFFFF, 3'b111, 1);
    run_vec("rm_other",    30'h1000_0030, 0, 2'b00, 0, 3'b111, 24'h800002, 3'b000, 1);
    run_vec("hi_sticky",   30'h2000_0021, 0, 2'b00, 0, RNE,    24'h800001, 3'b001, 1);
    run_vec("dec_nonzero", 30'h1000_0020, 1, 2'b00, 0, RNE,    24'h800001, 3'b000, 1);
    run_vec("nodec_ref",   30'h1000_0020, 0, 2'b00, 0, RNE,    24'h800001, 3'b000, 0);

    // ---- backpressure: result held, stray operand ignored
    drive_op(30'h1000_0030, 0, 2'b00, 0, RNE);
    wait_result(lat);
    check("bp_latency", lat, 4);
    bus.q        = 30'h2000_0000;
    bus.rm       = RNE;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready",  bus.in_ready,  0);
      check("bp_mant",      bus.mant,      24'h800002);
      check("bp_exp_adj",   bus.exp_adj,   3'b000);
      check("bp_inexact",   bus.inexact,   1);
      check("bp_state",     state_dbg,     ST_HOLD);
    end
    bus.in_valid = 1'b0;
    take_result("bp");
    expect_quiet("bp_no_stray_result", 6);

    // ---- reset while in NORM
    drive_op(30'h2000_0000, 0, 2'b00, 0, RNE);
    @(posedge clk);
    #1;
    check("mid_rst_in_norm", state_dbg, ST_NORM);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready",  bus.in_ready,  1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_mant",      bus.mant,      0);
    check("mid_rst_state",     state_dbg,     ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    expect_quiet("mid_rst_no_result", 6);

    // ---- flush while in RND: no result, output registers untouched
    drive_op(30'h1000_0010, 0, 2'b00, 0, RUP);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("flush_in_rnd", state_dbg, ST_RND);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_state",    state_dbg,     ST_IDLE);
    check("flush_in_ready", bus.in_ready,  1);
    check("flush_mant",     bus.mant,      0);
    expect_quiet("flush_no_result", 6);
    run_vec("after_flush", 30'h1000_0010, 0, 2'b00, 0, RUP, 24'h800001, 3'b000, 1);

    // ---- flush together with in_valid in IDLE drops the operand
    @(negedge clk);
    bus.q        = 30'h2000_0000;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
    check("flush_idle_state",    state_dbg,    ST_IDLE);
    check("flush_idle_in_ready", bus.in_ready, 1);
    expect_quiet("flush_idle_dropped", 6);

    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/goldschmidt_round.md
Name: goldschmidt_round

Overview:
- Downstream finalisation stage for the Goldschmidt divide/sqrt datapath.
- Captures the raw iteration result `q` and the remainder sign `r_sign` once the controller finishes.
- For division, applies a one-ulp remainder correction, then normalises to a leading one and rounds to an OUTW-bit mantissa under the selected rounding mode.
- Presents mantissa, exponent adjustment and inexact flag to the FP packing logic over a valid/ready handshake.

Parameters:
- LEADS, 2, integer bits of `q` (matches the iteration datapath).
- WIDTH, 28, fraction bits of `q`.
- OUTW, 24, output mantissa width including hidden bit; must satisfy OUTW <= WIDTH-2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; returns FSM to IDLE.
- in_valid  input  1  `q`/`r_sign`/`op`/`sign`/`rm` valid.
- in_ready  output  1  block can accept an operand.
- op  input  2  2'b00 = divide; any other value = sqrt.
- q  input  LEADS+WIDTH  raw result, fixed point, LEADS integer bits.
- r_sign  input  1  1 = q*d > n (quotient one ulp too large).
- sign  input  1  result sign; used by directed rounding only.
- rm  input  3  rounding mode: 000 RNE, 001 RZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE.
- out_valid  output  1  result held valid.
- out_ready  input  1  consumer accepts result.
- mant  output  OUTW  rounded mantissa; MSB = leading one.
- exp_adj  output  3  signed exponent adjustment (two's complement).
- inexact  output  1  any discarded nonzero information.

Behaviour:
- Reset values:
  - FSM = IDLE; in_ready=1, out_valid=0, mant=0, exp_adj=0, inexact=0.
  - All capture registers cleared.
- States: IDLE -> CORR -> NORM -> RND -> HOLD -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, register `q`, `r_sign`, `op`, `sign`, `rm`; go to CORR.
  - in_ready is 0 in every other state.
- CORR:
  - qc = q-1 when op==2'b00 && r_sign && q!=0; otherwise qc = q.
  - If q==0, no decrement is applied (no wrap).
  - Record dec = 1 when the decrement was applied.
- NORM: let S = LEADS+WIDTH and L = S-LEADS (index of the ones bit).
  - qc[L+1]=1: window qc[L+1 -: OUTW], guard qc[L+1-OUTW], sticky = OR of the bits below guard, e = +1.
  - else qc[L]=1: window from qc[L], e = 0.
  - else qc[L-1]=1: window from qc[L-1], e = -1.
  - else: mant=0, e=0, guard=sticky=0 (zero result).
  - Bits above qc[L+1] are ignored.
- RND: round-up decision.
  - RNE: g & (s | lsb).
  - RZ: 0.
  - RDN: sign & (g|s).
  - RUP: ~sign & (g|s).
  - RMM: g.
  - If the window is all ones and round-up is taken: mant = 1 followed by OUTW-1 zeros, exp_adj = e+1.
  - Otherwise mant = window + roundup, exp_adj = e.
  - inexact = g | s | dec.
  - Outputs are registered at the end of RND; out_valid rises on entry to HOLD.
- Latency: handshake in cycle 0 -> out_valid=1 in cycle 4.
- HOLD:
  - out_valid=1; mant, exp_adj and inexact are stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE; out_valid=0 and in_ready=1 in the next cycle.
  - No same-cycle accept of a new operand.
- flush:
  - Has priority over all transitions; next state IDLE, out_valid=0.
  - Output data registers keep their last values.
  - flush together with in_valid in IDLE: operand is dropped.
- Reset asserted mid-operation: immediately IDLE with all reset values; any pending result is lost.
- Sqrt (op!=2'b00): r_sign is ignored and dec=0.

Test Plan:
- q=30'h1000_0000, r_sign=0, op=00, rm=RNE -> mant=24'h800000, exp_adj=0, inexact=0, out_valid 4 cycles after accept.
- q=30'h1000_0010, rm=RNE -> mant=24'h800000, inexact=1 (tie to even). Same q with rm=RUP, sign=0 -> mant=24'h800001. Same q with RUP, sign=1 -> mant=24'h800000.
- q=30'h1000_0000, r_sign=1, op=00, RNE -> qc=30'h0FFF_FFFF; window all ones with g=1 -> mant=24'h800000, exp_adj=0, inexact=1. Same stimulus with op=01 -> mant=24'h800000, inexact=0.
- q=30'h2000_0000 -> mant=24'h800000, exp_adj=+1. q=0 with r_sign=1 -> mant=0, exp_adj=0, inexact=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, no new operand accepted. Raise out_ready -> out_valid falls and in_ready rises the next cycle.
- Assert reset in NORM -> in_ready=1, out_valid=0 immediately. Assert flush in RND -> IDLE next cycle and no out_valid pulse; the next operand then completes normally.
